// File: rtl/pc_sequencer.sv
// Multicycle fetch controller: owns the PC, issues one fetch per instruction,
// holds it for decode and commits the selected next PC. Optional PC_ALIGN_CHECK_EN traps misaligned targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ack,
  input  logic [31:0] if_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        instr_valid,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic        br_taken,
  input  logic [31:0] npc4,
  input  logic [31:0] npcb,
  input  logic [31:0] npcj,
  input  logic [31:0] npcjr,
  output logic [31:0] retire_cnt,
  output logic        exc_flag,
  output logic [31:0] exc_pc
);

  typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc4_reg;
  logic        instr_valid_reg;
  logic [31:0] retire_cnt_reg;
  logic [31:0] target;
  logic        misaligned;
  logic [31:0] commit_pc;
  logic        fetch_done;
  logic        commit;

  always_comb begin
    target = npc4;
    case (pc_sel)
      2'b00: target = npc4;
      2'b01: target = br_taken ? npcb : npc4;
      2'b10: target = npcj;
      2'b11: target = npcjr;
      default: target = npc4;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = (target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif
  assign commit_pc = misaligned ? EXC_VECTOR : target;

  assign fetch_done = (state_reg == FETCH) && if_ack;
  assign commit     = (state_reg == ISSUE) && !stall;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:   if (if_ack) state_next = ISSUE;
      ISSUE:   if (!stall) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'h0;
      pc4_reg         <= 32'h0;
      instr_valid_reg <= 1'b0;
      retire_cnt_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (fetch_done) begin
        instr_reg       <= if_rdata;
        pc4_reg         <= pc_reg + 32'd4;
        instr_valid_reg <= 1'b1;
      end
      if (commit) begin
        pc_reg          <= commit_pc;
        retire_cnt_reg  <= retire_cnt_reg + 32'd1;
        instr_valid_reg <= 1'b0;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic        exc_flag_reg;
  logic [31:0] exc_pc_reg;

  // exc_flag is a single-cycle pulse; exc_pc keeps the last offending target.
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_flag_reg <= 1'b0;
      exc_pc_reg   <= 32'h0;
    end else begin
      exc_flag_reg <= commit && misaligned;
      if (commit && misaligned) exc_pc_reg <= target;
    end
  end

  assign exc_flag = exc_flag_reg;
  assign exc_pc   = exc_pc_reg;
`else
  assign exc_flag = 1'b0;
  assign exc_pc   = 32'h0;
`endif

  // The request is dropped combinationally while reset is held so an
  // in-flight fetch is abandoned in the reset cycle itself.
  assign if_req      = (state_reg == FETCH) && !reset;
  assign if_addr     = pc_reg;
  assign instr       = instr_reg;
  assign pc4         = pc4_reg;
  assign instr_valid = instr_valid_reg;
  assign retire_cnt  = retire_cnt_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch/issue sequencing, target selection,
// stall, delayed ack, mid-fetch reset, alignment trap and pc4 wrap.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        instr_valid;
  logic        stall;
  logic [1:0]  pc_sel;
  logic        br_taken;
  logic [31:0] npc4, npcb, npcj, npcjr;
  logic [31:0] retire_cnt;
  logic        exc_flag;
  logic [31:0] exc_pc;

  int compared = 0;
  int mismatched = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata), .instr(instr), .pc4(pc4),
    .instr_valid(instr_valid), .stall(stall), .pc_sel(pc_sel),
    .br_taken(br_taken), .npc4(npc4), .npcb(npcb), .npcj(npcj),
    .npcjr(npcjr), .retire_cnt(retire_cnt), .exc_flag(exc_flag),
    .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; if_ack = 1'b0; if_rdata = 32'h0; stall = 1'b0;
    pc_sel = 2'b00; br_taken = 1'b0;
    npc4 = 32'h0; npcb = 32'h0; npcj = 32'h0; npcjr = 32'h0;

    step(); step();
    check("rst_if_req", {31'h0, if_req}, 32'h0);
    check("rst_if_addr", if_addr, 32'h0000_3000);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc4", pc4, 32'h0);
    check("rst_retire", retire_cnt, 32'h0);
    check("rst_exc_flag", {31'h0, exc_flag}, 32'h0);
    check("rst_exc_pc", exc_pc, 32'h0);

    // Zero-wait first fetch
    reset = 1'b0;
    #1;
    check("f0_if_req", {31'h0, if_req}, 32'h1);
    check("f0_if_addr", if_addr, 32'h0000_3000);
    check("f0_valid", {31'h0, instr_valid}, 32'h0);
    if_ack = 1'b1; if_rdata = 32'h2008_0005;
    step();
    if_ack = 1'b0;
    check("i0_valid", {31'h0, instr_valid}, 32'h1);
    check("i0_instr", instr, 32'h2008_0005);
    check("i0_pc4", pc4, 32'h0000_3004);
    check("i0_if_req", {31'h0, if_req}, 32'h0);

    // Branch not taken
    pc_sel = 2'b01; br_taken = 1'b0; npc4 = 32'h0000_3004; npcb = 32'h0000_3100;
    step();
    check("bnt_if_addr", if_addr, 32'h0000_3004);
    check("bnt_if_req", {31'h0, if_req}, 32'h1);
    check("bnt_retire", retire_cnt, 32'h1);
    check("bnt_valid", {31'h0, instr_valid}, 32'h0);
    if_ack = 1'b1; if_rdata = 32'h1111_2222;
    step();
    if_ack = 1'b0;
    check("i1_pc4", pc4, 32'h0000_3008);
    check("i1_instr", instr, 32'h1111_2222);

    // Branch taken
    br_taken = 1'b1; npc4 = 32'h0000_3008;
    step();
    check("bt_if_addr", if_addr, 32'h0000_3100);
    check("bt_retire", retire_cnt, 32'h2);
    if_ack = 1'b1; if_rdata = 32'h3333_4444;
    step();
    if_ack = 1'b0;
    check("i2_pc4", pc4, 32'h0000_3104);

    // Stall five cycles with jr pending
    stall = 1'b1; pc_sel = 2'b11; npcjr = 32'h0000_3ABC; br_taken = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_if_req", {31'h0, if_req}, 32'h0);
      check("stall_retire", retire_cnt, 32'h2);
      check("stall_valid", {31'h0, instr_valid}, 32'h1);
    end
    stall = 1'b0;
    step();
    check("jr_if_addr", if_addr, 32'h0000_3ABC);
    check("jr_retire", retire_cnt, 32'h3);
    check("jr_if_req", {31'h0, if_req}, 32'h1);

    // Delayed ack: address and request held
    for (int k = 0; k < 3; k++) begin
      step();
      check("wait_if_addr", if_addr, 32'h0000_3ABC);
      check("wait_if_req", {31'h0, if_req}, 32'h1);
    end
    if_ack = 1'b1; if_rdata = 32'h5555_6666;
    step();
    check("dly_instr", instr, 32'h5555_6666);
    check("dly_pc4", pc4, 32'h0000_3AC0);
    // Stray ack during ISSUE while stalled
    stall = 1'b1; if_rdata = 32'hDEAD_BEEF;
    step();
    check("stray_instr", instr, 32'h5555_6666);
    check("stray_valid", {31'h0, instr_valid}, 32'h1);
    if_ack = 1'b0;

    // Jump to 3040 via j, then reset mid-fetch
    stall = 1'b0; pc_sel = 2'b10; npcj = 32'h0000_3040;
    step();
    check("j_if_addr", if_addr, 32'h0000_3040);
    check("j_retire", retire_cnt, 32'h4);
    reset = 1'b1;
    step();
    check("mrst_if_addr", if_addr, 32'h0000_3000);
    check("mrst_if_req", {31'h0, if_req}, 32'h0);
    check("mrst_valid", {31'h0, instr_valid}, 32'h0);
    check("mrst_retire", retire_cnt, 32'h0);
    reset = 1'b0;
    #1;
    check("mrst_req_back", {31'h0, if_req}, 32'h1);

    // Misaligned jr target
    if_ack = 1'b1; if_rdata = 32'h0000_0008;
    step();
    if_ack = 1'b0;
    pc_sel = 2'b11; npcjr = 32'h0000_3002;
    step();
    check("al_retire", retire_cnt, 32'h1);
`ifdef PC_ALIGN_CHECK_EN
    check("al_if_addr", if_addr, 32'h0000_4180);
    check("al_exc_flag", {31'h0, exc_flag}, 32'h1);
    check("al_exc_pc", exc_pc, 32'h0000_3002);
    step();
    check("al_exc_flag_clr", {31'h0, exc_flag}, 32'h0);
`else
    check("al_if_addr", if_addr, 32'h0000_3002);
    check("al_exc_flag", {31'h0, exc_flag}, 32'h0);
    check("al_exc_pc", exc_pc, 32'h0);
    step();
    check("al_exc_flag_hold", {31'h0, exc_flag}, 32'h0);
`endif

    // pc4 wrap at the top of the address space
    if_ack = 1'b1; if_rdata = 32'h0;
    step();
    if_ack = 1'b0;
    npcjr = 32'hFFFF_FFFC;
    step();
    check("top_if_addr", if_addr, 32'hFFFF_FFFC);
    if_ack = 1'b1; if_rdata = 32'h7777_8888;
    step();
    if_ack = 1'b0;
    check("wrap_pc4", pc4, 32'h0);
    check("wrap_instr", instr, 32'h7777_8888);
    check("wrap_retire", retire_cnt, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
